fpu_mem_controller: RTL and testbench
=====================================

Name: fpu_mem_controller

Overview:
Responder side of the core's memory-request interface: accepts read/write requests from NUM_CONSUMERS core-side load/store requesters and serialises them onto one external memory channel. Round-robin arbitration, one outstanding memory transaction at a time, per-consumer valid/ready handshakes. Sits between the FPU cores and data memory; a second instance serves program memory with WRITE_ENABLE=0.

Parameters:
ADDR_BITS, 8, memory address width
DATA_BITS, 8, memory data width
NUM_CONSUMERS, 4, number of requesters (power of 2 not required, >=1)
WRITE_ENABLE, 1, 1 = write path present; 0 = read-only (program memory)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request
consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed, consumer i at [i*ADDR_BITS +: ADDR_BITS]
consumer_read_ready  out  NUM_CONSUMERS  read data valid / request done
consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed returned data
consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed
consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed
consumer_write_ready  out  NUM_CONSUMERS  write complete
mem_read_valid  out  1  memory read request
mem_read_address  out  ADDR_BITS
mem_read_ready  in  1  memory read data valid (one-cycle pulse or level)
mem_read_data  in  DATA_BITS
mem_write_valid  out  1  memory write request
mem_write_address  out  ADDR_BITS
mem_write_data  out  DATA_BITS
mem_write_ready  in  1  memory write accepted

Behaviour:
- Reset (any cycle, incl. mid-transaction): state=IDLE, rr_ptr=0, all outputs 0 (all ready bits, mem_*_valid, addresses, data). In-flight memory transaction abandoned; memory must tolerate valid dropping.
- States: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- IDLE: search consumers rr_ptr, rr_ptr+1, ... wrapping mod NUM_CONSUMERS; first i with read_valid or write_valid wins. Same consumer asserting both: read served first. Register grant index g; for read: mem_read_valid<=1, mem_read_address<=addr[g], ->READ_WAIT; for write: mem_write_valid<=1, address/data latched, ->WRITE_WAIT. No request: stay IDLE.
- READ_WAIT: on mem_read_ready: mem_read_valid<=0, consumer_read_data[g]<=mem_read_data, consumer_read_ready[g]<=1, ->RELAY. Else hold all outputs.
- WRITE_WAIT: on mem_write_ready: mem_write_valid<=0, consumer_write_ready[g]<=1, ->RELAY.
- RELAY: wait until consumer g deasserts the served valid; then clear its ready, rr_ptr<=(g+1) mod NUM_CONSUMERS, ->IDLE. consumer_read_data[g] held until next read to g (not cleared).
- Only one ready bit high at any time; mem_read_valid and mem_write_valid never both high.
- Latency with zero-wait memory: valid seen in cycle 0 -> mem_*_valid cycle 1 -> ready to consumer cycle 2 (if mem ready same cycle as valid sampled) ; min 4 cycles IDLE-to-IDLE per transaction.
- Consumer must hold address/data stable while valid high; controller latches at grant so later changes are ignored.
- WRITE_ENABLE=0: write inputs ignored, mem_write_* and consumer_write_ready constant 0, WRITE_WAIT unreachable.
- Consumer deasserting valid before ready: undefined request, controller still completes memory transaction and passes through RELAY (valid already low -> IDLE next cycle).

Test Plan:
- Single read: consumer 2 reads addr 0x3C, memory returns 0xA5 one cycle after mem_read_valid -> mem_read_address=0x3C, consumer_read_data[2]=0xA5, consumer_read_ready=4'b0100 until valid drops.
- Round-robin fairness: all 4 consumers hold read_valid from reset -> service order 0,1,2,3,0; no consumer served twice before others.
- Write: consumer 1 writes 0x7E to 0x10, mem_write_ready after 3 cycles -> mem_write_valid held 3 cycles with addr 0x10/data 0x7E, then consumer_write_ready=4'b0010.
- Read+write same consumer 0 simultaneously -> read issued first, write issued after RELAY with rr_ptr wrapping back only after others idle.
- Reset asserted during READ_WAIT -> next cycle all outputs 0, state IDLE, rr_ptr=0; request reissued from consumer 0 after reset release.
- WRITE_ENABLE=0 instance: write_valid on consumer 3 -> mem_write_valid stays 0, consumer_write_ready stays 0, concurrent reads unaffected.

Source files
------------

// File: rtl/fpu_mem_controller.sv
// fpu_mem_controller: serialises read/write requests from NUM_CONSUMERS
// load/store requesters onto one external memory channel. Round-robin
// arbitration, one memory transaction in flight, per-consumer valid/ready.
// The WRITE_ENABLE=0 build serves program memory (read-only).
module fpu_mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,
    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready
);

    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [IDX_BITS:0]   NUM_W    = (IDX_BITS+1)'(NUM_CONSUMERS);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CONSUMERS - 1);
    localparam logic                WE_BIT   = (WRITE_ENABLE != 0);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] READ_WAIT  = 2'd1;
    localparam logic [1:0] WRITE_WAIT = 2'd2;
    localparam logic [1:0] RELAY      = 2'd3;

    logic [1:0]               state;
    logic [IDX_BITS-1:0]      rr_ptr;
    logic [IDX_BITS-1:0]      grant;
    logic                     served_read;
    logic [NUM_CONSUMERS-1:0] read_ready_q;
    logic [NUM_CONSUMERS-1:0] write_ready_q;
    logic                     mem_rv_q;
    logic                     mem_wv_q;
    logic [ADDR_BITS-1:0]     mem_ra_q;
    logic [ADDR_BITS-1:0]     mem_wa_q;
    logic [DATA_BITS-1:0]     mem_wd_q;

    // Unpacked per-consumer views of the packed buses.
    logic [ADDR_BITS-1:0]     rd_addr   [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]     wr_addr   [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     wr_data   [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     rd_data_q [NUM_CONSUMERS];

    // Write requests vanish entirely in the read-only build, so the write
    // path can never be granted and WRITE_WAIT is unreachable.
    logic [NUM_CONSUMERS-1:0] write_req;
    assign write_req = consumer_write_valid & {NUM_CONSUMERS{WE_BIT}};

    for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_lane
        assign rd_addr[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        assign wr_addr[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        assign wr_data[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
        assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = rd_data_q[i];
    end

    // Round-robin search starting at rr_ptr; reads beat writes on one consumer.
    logic                pick_found;
    logic                pick_read;
    logic [IDX_BITS-1:0] pick_idx;
    logic [IDX_BITS:0]   sum;

    always_comb begin
        pick_found = 1'b0;
        pick_read  = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_BITS+1)'(k);
            if (sum >= NUM_W) sum = sum - NUM_W;
            if (!pick_found && (consumer_read_valid[sum[IDX_BITS-1:0]] ||
                                write_req[sum[IDX_BITS-1:0]])) begin
                pick_found = 1'b1;
                pick_idx   = sum[IDX_BITS-1:0];
                pick_read  = consumer_read_valid[sum[IDX_BITS-1:0]];
            end
        end
    end

    // The valid that keeps RELAY waiting is the one that was actually served.
    logic                relay_valid;
    logic [IDX_BITS-1:0] next_ptr;
    assign relay_valid = served_read ? consumer_read_valid[grant] : write_req[grant];
    assign next_ptr    = (grant == LAST_IDX) ? '0 : grant + IDX_BITS'(1);

    // Controller FSM: grant, drive memory, relay completion, release.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant         <= '0;
            served_read   <= 1'b0;
            read_ready_q  <= '0;
            write_ready_q <= '0;
            mem_rv_q      <= 1'b0;
            mem_wv_q      <= 1'b0;
            mem_ra_q      <= '0;
            mem_wa_q      <= '0;
            mem_wd_q      <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) rd_data_q[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant       <= pick_idx;
                        served_read <= pick_read;
                        if (pick_read) begin
                            mem_rv_q <= 1'b1;
                            mem_ra_q <= rd_addr[pick_idx];
                            state    <= READ_WAIT;
                        end else begin
                            mem_wv_q <= 1'b1;
                            mem_wa_q <= wr_addr[pick_idx];
                            mem_wd_q <= wr_data[pick_idx];
                            state    <= WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready) begin
                        mem_rv_q            <= 1'b0;
                        rd_data_q[grant]    <= mem_read_data;
                        read_ready_q[grant] <= 1'b1;
                        state               <= RELAY;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready) begin
                        mem_wv_q             <= 1'b0;
                        write_ready_q[grant] <= 1'b1;
                        state                <= RELAY;
                    end
                end
                RELAY: begin
                    // Read data stays put after ready drops; only the next
                    // read to the same consumer overwrites it.
                    if (!relay_valid) begin
                        read_ready_q  <= '0;
                        write_ready_q <= '0;
                        rr_ptr        <= next_ptr;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign consumer_read_ready  = read_ready_q;
    assign mem_read_valid       = mem_rv_q;
    assign mem_read_address     = mem_ra_q;
    assign consumer_write_ready = write_ready_q & {NUM_CONSUMERS{WE_BIT}};
    assign mem_write_valid      = mem_wv_q & WE_BIT;
    assign mem_write_address    = mem_wa_q & {ADDR_BITS{WE_BIT}};
    assign mem_write_data       = mem_wd_q & {DATA_BITS{WE_BIT}};

endmodule

// File: tb/tb_fpu_mem_controller.sv
// Testbench for fpu_mem_controller: cycle-by-cycle vector table plus
// hand-written round-robin and read-only-instance sequences.
module tb_fpu_mem_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  rv, wv;
    logic [31:0] raddr, waddr, wdata;
    logic        mrr, mwr;
    logic [7:0]  mrd;
    logic [3:0]  crr, cwr;
    logic [31:0] crd;
    logic        mrv, mwv;
    logic [7:0]  mra, mwa, mwd;

    logic        ro_mrr, ro_mwr;
    logic [7:0]  ro_mrd;
    logic [3:0]  ro_crr, ro_cwr;
    logic [31:0] ro_crd;
    logic        ro_mrv, ro_mwv;
    logic [7:0]  ro_mra, ro_mwa, ro_mwd;

    int checks = 0;
    int errors = 0;

    fpu_mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(raddr),
        .consumer_read_ready(crr), .consumer_read_data(crd),
        .consumer_write_valid(wv), .consumer_write_address(waddr),
        .consumer_write_data(wdata), .consumer_write_ready(cwr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd),
        .mem_write_ready(mwr)
    );

    fpu_mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .WRITE_ENABLE(0)) dut_ro (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(raddr),
        .consumer_read_ready(ro_crr), .consumer_read_data(ro_crd),
        .consumer_write_valid(wv), .consumer_write_address(waddr),
        .consumer_write_data(wdata), .consumer_write_ready(ro_cwr),
        .mem_read_valid(ro_mrv), .mem_read_address(ro_mra),
        .mem_read_ready(ro_mrr), .mem_read_data(ro_mrd),
        .mem_write_valid(ro_mwv), .mem_write_address(ro_mwa), .mem_write_data(ro_mwd),
        .mem_write_ready(ro_mwr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rv, wv;
        logic        mrr;
        logic [7:0]  mrd;
        logic        mwr;
        logic [3:0]  crr, cwr;
        logic [31:0] crd;
        logic        mrv;
        logic [7:0]  mra;
        logic        mwv;
        logic [7:0]  mwa, mwd;
    } vec_t;

    localparam int NV = 30;
    vec_t vt [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] got8;
        bit         seen;
        int         e;

        reset = 1'b1; rv = '0; wv = '0; mrr = 1'b0; mrd = '0; mwr = 1'b0;
        ro_mrr = 1'b0; ro_mrd = '0; ro_mwr = 1'b0;
        raddr = {8'h40, 8'h3C, 8'h21, 8'h08};
        waddr = {8'h30, 8'h90, 8'h10, 8'h20};
        wdata = {8'hD3, 8'hC2, 8'h7E, 8'h55};

        //          rst rv    wv    mrr mrd    mwr  crr   cwr   crd           mrv mra    mwv mwa    mwd
        // reset
        vt[0]  = '{1, 4'h0, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00000000, 0, 8'h00, 0, 8'h00, 8'h00};
        // single read, consumer 2, addr 0x3C, data 0xA5
        vt[1]  = '{0, 4'h4, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00000000, 1, 8'h3C, 0, 8'h00, 8'h00};
        vt[2]  = '{0, 4'h4, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00000000, 1, 8'h3C, 0, 8'h00, 8'h00};
        vt[3]  = '{0, 4'h4, 4'h0, 1, 8'hA5, 0,   4'h4, 4'h0, 32'h00A50000, 0, 8'h3C, 0, 8'h00, 8'h00};
        vt[4]  = '{0, 4'h4, 4'h0, 0, 8'h00, 0,   4'h4, 4'h0, 32'h00A50000, 0, 8'h3C, 0, 8'h00, 8'h00};
        vt[5]  = '{0, 4'h0, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00A50000, 0, 8'h3C, 0, 8'h00, 8'h00};
        // write, consumer 1, 0x7E to 0x10, memory ready after 3 cycles
        vt[6]  = '{0, 4'h0, 4'h2, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00A50000, 0, 8'h3C, 1, 8'h10, 8'h7E};
        vt[7]  = '{0, 4'h0, 4'h2, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00A50000, 0, 8'h3C, 1, 8'h10, 8'h7E};
        vt[8]  = '{0, 4'h0, 4'h2, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00A50000, 0, 8'h3C, 1, 8'h10, 8'h7E};
        vt[9]  = '{0, 4'h0, 4'h2, 0, 8'h00, 1,   4'h0, 4'h2, 32'h00A50000, 0, 8'h3C, 0, 8'h10, 8'h7E};
        vt[10] = '{0, 4'h0, 4'h2, 0, 8'h00, 0,   4'h0, 4'h2, 32'h00A50000, 0, 8'h3C, 0, 8'h10, 8'h7E};
        vt[11] = '{0, 4'h0, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00A50000, 0, 8'h3C, 0, 8'h10, 8'h7E};
        // consumer 0 read+write together: read first, write after RELAY
        vt[12] = '{0, 4'h1, 4'h1, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00A50000, 1, 8'h08, 0, 8'h10, 8'h7E};
        vt[13] = '{0, 4'h1, 4'h1, 1, 8'h5A, 0,   4'h1, 4'h0, 32'h00A5005A, 0, 8'h08, 0, 8'h10, 8'h7E};
        vt[14] = '{0, 4'h0, 4'h1, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00A5005A, 0, 8'h08, 0, 8'h10, 8'h7E};
        vt[15] = '{0, 4'h0, 4'h1, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00A5005A, 0, 8'h08, 1, 8'h20, 8'h55};
        vt[16] = '{0, 4'h0, 4'h1, 0, 8'h00, 1,   4'h0, 4'h1, 32'h00A5005A, 0, 8'h08, 0, 8'h20, 8'h55};
        vt[17] = '{0, 4'h0, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00A5005A, 0, 8'h08, 0, 8'h20, 8'h55};
        // consumer 3 drops valid before ready: transaction still completes
        vt[18] = '{0, 4'h8, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00A5005A, 1, 8'h40, 0, 8'h20, 8'h55};
        vt[19] = '{0, 4'h0, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00A5005A, 1, 8'h40, 0, 8'h20, 8'h55};
        vt[20] = '{0, 4'h0, 4'h0, 1, 8'hC3, 0,   4'h8, 4'h0, 32'hC3A5005A, 0, 8'h40, 0, 8'h20, 8'h55};
        vt[21] = '{0, 4'h0, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'hC3A5005A, 0, 8'h40, 0, 8'h20, 8'h55};
        // reset during READ_WAIT, then rr_ptr back at consumer 0
        vt[22] = '{0, 4'h2, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'hC3A5005A, 1, 8'h21, 0, 8'h20, 8'h55};
        vt[23] = '{1, 4'h2, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00000000, 0, 8'h00, 0, 8'h00, 8'h00};
        vt[24] = '{0, 4'h3, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00000000, 1, 8'h08, 0, 8'h00, 8'h00};
        vt[25] = '{0, 4'h3, 4'h0, 1, 8'h77, 0,   4'h1, 4'h0, 32'h00000077, 0, 8'h08, 0, 8'h00, 8'h00};
        vt[26] = '{0, 4'h2, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00000077, 0, 8'h08, 0, 8'h00, 8'h00};
        vt[27] = '{0, 4'h2, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00000077, 1, 8'h21, 0, 8'h00, 8'h00};
        vt[28] = '{0, 4'h2, 4'h0, 1, 8'h88, 0,   4'h2, 4'h0, 32'h00008877, 0, 8'h21, 0, 8'h00, 8'h00};
        vt[29] = '{0, 4'h0, 4'h0, 0, 8'h00, 0,   4'h0, 4'h0, 32'h00008877, 0, 8'h21, 0, 8'h00, 8'h00};

        for (int i = 0; i < NV; i++) begin
            reset = vt[i].rst; rv = vt[i].rv; wv = vt[i].wv;
            mrr = vt[i].mrr; mrd = vt[i].mrd; mwr = vt[i].mwr;
            tick();
            chk("crr", i, {28'h0, crr}, {28'h0, vt[i].crr});
            chk("cwr", i, {28'h0, cwr}, {28'h0, vt[i].cwr});
            chk("crd", i, crd, vt[i].crd);
            chk("mrv", i, {31'h0, mrv}, {31'h0, vt[i].mrv});
            chk("mra", i, {24'h0, mra}, {24'h0, vt[i].mra});
            chk("mwv", i, {31'h0, mwv}, {31'h0, vt[i].mwv});
            chk("mwa", i, {24'h0, mwa}, {24'h0, vt[i].mwa});
            chk("mwd", i, {24'h0, mwd}, {24'h0, vt[i].mwd});
        end

        // Round-robin: all four hold read_valid from reset -> order 0,1,2,3,0.
        reset = 1'b1; rv = '0; wv = '0; mrr = 1'b0; mwr = 1'b0;
        tick();
        reset = 1'b0; rv = 4'hF;
        for (int n = 0; n < 5; n++) begin
            e = n % 4;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                tick();
                if (mrv) seen = 1'b1;
            end
            chk("rr_issue", n, {31'h0, seen}, 32'h1);
            got8 = 8'(raddr >> (e*8));
            chk("rr_addr", n, {24'h0, mra}, {24'h0, got8});
            mrr = 1'b1; mrd = 8'hE0 + 8'(n);
            tick();
            mrr = 1'b0;
            chk("rr_ready", n, {28'h0, crr}, {28'h0, 4'(1 << e)});
            got8 = 8'(crd >> (e*8));
            chk("rr_data", n, {24'h0, got8}, {24'h0, 8'hE0 + 8'(n)});
            rv[e] = 1'b0;
            tick();
            chk("rr_release", n, {28'h0, crr}, 32'h0);
            rv[e] = 1'b1;
        end

        // Read-only instance: write on consumer 3 ignored, read on 2 served.
        reset = 1'b1; rv = '0; wv = '0;
        tick();
        reset = 1'b0; rv = 4'h4; wv = 4'h8; ro_mwr = 1'b1; ro_mrr = 1'b0;
        tick();
        chk("ro_mrv", 0, {31'h0, ro_mrv}, 32'h1);
        chk("ro_mra", 0, {24'h0, ro_mra}, 32'h3C);
        for (int c = 0; c < 3; c++) begin
            chk("ro_mwv", c, {31'h0, ro_mwv}, 32'h0);
            chk("ro_cwr", c, {28'h0, ro_cwr}, 32'h0);
            tick();
        end
        ro_mrr = 1'b1; ro_mrd = 8'h5C;
        tick();
        ro_mrr = 1'b0;
        chk("ro_crr", 0, {28'h0, ro_crr}, 32'h4);
        chk("ro_crd", 0, ro_crd, 32'h005C0000);
        rv = 4'h0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("ro_mwv_idle", c, {31'h0, ro_mwv}, 32'h0);
            chk("ro_cwr_idle", c, {28'h0, ro_cwr}, 32'h0);
            chk("ro_mwa", c, {16'h0, ro_mwa, ro_mwd}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
